// File: rtl/key_reader_pkg.sv
// Shared types and 50 MHz default timing constants for the pushbutton reader.
package key_reader_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DEB,
    HELD,
    LONG,
    RELEASE_DEB
  } key_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int DEFAULT_HOLD_CYCLES     = 50_000_000; // 1 s at 50 MHz

  // The debounced level stays high until a release has been fully accepted.
  function automatic logic is_pressed(key_state_t s);
    return s inside {HELD, LONG, RELEASE_DEB};
  endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: 2-flop synchroniser, debounce counter and press/hold/release FSM.
module key_channel
  import key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // must be >= 2
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES       // must be >= 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_evt,
  output logic release_evt,
  output logic hold_evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [1:0]    sync;
  logic          p;
  key_state_t    state, state_nx;
  logic [DW-1:0] deb_cnt, deb_cnt_nx;
  logic [HW-1:0] hold_cnt, hold_cnt_nx, hold_step;
  logic          fired, fired_nx;
  logic          press_q, release_q, hold_q;
  logic          press_nx, release_nx, hold_nx;

  assign p = ~sync[1];
  // Hold timing parks at its last value so a release bounce cannot skip the match.
  assign hold_step = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HW'(1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // which is what makes the two sync stages a real shift rather than a wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      state     <= RELEASED;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      fired     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      sync      <= {sync[0], key_n};
      state     <= state_nx;
      deb_cnt   <= deb_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      fired     <= fired_nx;
      press_q   <= press_nx;
      release_q <= release_nx;
      hold_q    <= hold_nx;
    end
  end

  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    deb_cnt_nx  = deb_cnt;
    hold_cnt_nx = hold_cnt;
    fired_nx    = fired;
    press_nx    = 1'b0;
    release_nx  = 1'b0;
    hold_nx     = 1'b0;
    case (state)
      RELEASED: begin
        if (p) begin
          state_nx   = PRESS_DEB;
          deb_cnt_nx = DW'(1);
        end
      end
      PRESS_DEB: begin
        if (!p) begin
          state_nx   = RELEASED;
          deb_cnt_nx = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx    = HELD;
          deb_cnt_nx  = '0;
          hold_cnt_nx = '0;
          fired_nx    = 1'b0;
          press_nx    = 1'b1;
        end else begin
          deb_cnt_nx = deb_cnt + DW'(1);
        end
      end
      HELD: begin
        // Release detection beats a hold expiry landing in the same cycle.
        if (!p) begin
          state_nx    = RELEASE_DEB;
          deb_cnt_nx  = DW'(1);
          hold_cnt_nx = hold_step;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = LONG;
          fired_nx = 1'b1;
          hold_nx  = 1'b1;
        end else begin
          hold_cnt_nx = hold_step;
        end
      end
      LONG: begin
        if (!p) begin
          state_nx   = RELEASE_DEB;
          deb_cnt_nx = DW'(1);
        end
      end
      RELEASE_DEB: begin
        if (p) begin
          state_nx   = fired ? LONG : HELD;
          deb_cnt_nx = '0;
          if (!fired) hold_cnt_nx = hold_step;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx   = RELEASED;
          deb_cnt_nx = '0;
          release_nx = 1'b1;
        end else begin
          deb_cnt_nx = deb_cnt + DW'(1);
          if (!fired) hold_cnt_nx = hold_step;
        end
      end
      default: state_nx = RELEASED;
    endcase
  end

  always_comb begin
    pressed     = is_pressed(state);
    press_evt   = press_q;
    release_evt = release_q;
    hold_evt    = hold_q;
  end

endmodule

// File: rtl/key_reader.sv
// Debounced pushbutton bank: one independent key_channel per active-low KEY input.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] PRESSED,
  output logic [NUM_KEYS-1:0] PRESS,
  output logic [NUM_KEYS-1:0] RELEASE,
  output logic [NUM_KEYS-1:0] HOLD
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clk        (CLOCK_50),
      .reset      (RESET),
      .key_n      (KEY[i]),
      .pressed    (PRESSED[i]),
      .press_evt  (PRESS[i]),
      .release_evt(RELEASE[i]),
      .hold_evt   (HOLD[i])
    );
  end

endmodule
